// File: rtl/nl_wh_router.sv
// nl_wh_router: single-VC wormhole mesh router with XY routing, credit flow control and
// per-output round-robin with packet locking. Define NL_ROUTER_PERF_CNT_EN to build flit counters.
module nl_wh_router #(
  parameter int FLIT_W    = 34,
  parameter int BUF_DEPTH = 4,
  parameter int X_W       = 4,
  parameter int Y_W       = 4,
  parameter int NP        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [X_W-1:0]       x_cur,
  input  logic [Y_W-1:0]       y_cur,
  input  logic [NP*FLIT_W-1:0] flit_in,
  input  logic [NP-1:0]        valid_in,
  output logic [NP-1:0]        credit_out,
  output logic [NP*FLIT_W-1:0] flit_out,
  output logic [NP-1:0]        valid_out,
  input  logic [NP-1:0]        credit_in,
  output logic [NP-1:0]        ovf_err,
  output logic [NP*32-1:0]     flit_cnt
);

  // Per-output lock state
  //   state      | meaning
  //   OUT_IDLE   | free; next head from any input may be granted (round-robin)
  //   OUT_LOCKED | owned by owner_q until that packet's tail is sent

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CRD_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = $clog2(NP);

  localparam logic [IDX_W-1:0] P_LOCAL = IDX_W'(0);
  localparam logic [IDX_W-1:0] P_NORTH = IDX_W'(1);
  localparam logic [IDX_W-1:0] P_EAST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] P_SOUTH = IDX_W'(3);
  localparam logic [IDX_W-1:0] P_WEST  = IDX_W'(4);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(BUF_DEPTH);

  typedef enum logic {OUT_IDLE, OUT_LOCKED} out_state_e;

  logic [FLIT_W-1:0] fifo_mem [NP][BUF_DEPTH];
  logic [PTR_W:0]    wr_ptr   [NP];
  logic [PTR_W:0]    rd_ptr   [NP];
  logic [NP-1:0]     empty;
  logic [NP-1:0]     full;
  logic [NP-1:0]     push;
  logic [NP-1:0]     pop;
  logic [FLIT_W-1:0] front    [NP];
  logic [IDX_W-1:0]  req_port [NP];
  logic [IDX_W-1:0]  route_q  [NP];

  out_state_e        out_state [NP];
  logic [IDX_W-1:0]  owner_q   [NP];
  logic [IDX_W-1:0]  rr_q      [NP];
  logic [CRD_W-1:0]  credit_q  [NP];
  logic [NP-1:0]     send;
  logic [IDX_W-1:0]  grant     [NP];
  logic [FLIT_W-1:0] out_flit  [NP];

  function automatic logic [IDX_W-1:0] route_of(input logic [X_W+Y_W-1:0] dest,
                                                input logic [X_W-1:0]     xc,
                                                input logic [Y_W-1:0]     yc);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    dx = dest[X_W-1:0];
    dy = dest[X_W+Y_W-1:X_W];
    if (dx > xc)      return P_EAST;
    else if (dx < xc) return P_WEST;
    else if (dy > yc) return P_NORTH;
    else if (dy < yc) return P_SOUTH;
    return P_LOCAL;
  endfunction

  // Heads are routed live; body/tail flits reuse the route latched when the head left.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      front[p] = fifo_mem[p][rd_ptr[p][PTR_W-1:0]];
      empty[p] = (wr_ptr[p] == rd_ptr[p]);
      full[p]  = (wr_ptr[p][PTR_W] != rd_ptr[p][PTR_W]) &&
                 (wr_ptr[p][PTR_W-1:0] == rd_ptr[p][PTR_W-1:0]);
      req_port[p] = front[p][FLIT_W-1] ? route_of(front[p][X_W+Y_W-1:0], x_cur, y_cur)
                                       : route_q[p];
    end
  end

  always_comb begin : arb_comb
    logic found;
    int   idx;
    for (int o = 0; o < NP; o++) begin
      send[o]  = 1'b0;
      grant[o] = '0;
      found    = 1'b0;
      idx      = 0;
      if (out_state[o] == OUT_LOCKED) begin
        grant[o] = owner_q[o];
        send[o]  = !empty[owner_q[o]] && (req_port[owner_q[o]] == IDX_W'(o)) &&
                   (credit_q[o] != '0);
      end else begin
        for (int k = 0; k < NP; k++) begin
          idx = int'(rr_q[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!found && !empty[idx] && front[idx][FLIT_W-1] && (req_port[idx] == IDX_W'(o))) begin
            found    = 1'b1;
            grant[o] = IDX_W'(idx);
          end
        end
        send[o] = found && (credit_q[o] != '0);
      end
    end
  end

  // When full, a same-cycle pop frees the slot the push needs.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NP; o++) begin
      out_flit[o] = front[grant[o]];
      if (send[o]) pop[grant[o]] = 1'b1;
    end
    push = valid_in & (~full | pop);
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) fifo_mem[p][wr_ptr[p][PTR_W-1:0]] <= flit_in[p*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr[p]  <= '0;
        rd_ptr[p]  <= '0;
        route_q[p] <= P_LOCAL;
      end
      for (int o = 0; o < NP; o++) begin
        out_state[o] <= OUT_IDLE;
        owner_q[o]   <= '0;
        rr_q[o]      <= '0;
        credit_q[o]  <= CRD_MAX;
      end
      flit_out   <= '0;
      valid_out  <= '0;
      credit_out <= '0;
      ovf_err    <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p]) begin
          rd_ptr[p] <= rd_ptr[p] + 1'b1;
          if (front[p][FLIT_W-1]) route_q[p] <= req_port[p];
        end
        if (valid_in[p] && full[p] && !pop[p]) ovf_err[p] <= 1'b1;
      end
      for (int o = 0; o < NP; o++) begin
        if (send[o]) begin
          flit_out[o*FLIT_W +: FLIT_W] <= out_flit[o];
          if (out_flit[o][FLIT_W-2]) begin
            out_state[o] <= OUT_IDLE;
          end else if (out_flit[o][FLIT_W-1]) begin
            out_state[o] <= OUT_LOCKED;
            owner_q[o]   <= grant[o];
          end
          if (out_flit[o][FLIT_W-1])
            rr_q[o] <= (grant[o] == IDX_W'(NP-1)) ? '0 : grant[o] + IDX_W'(1);
        end
        case ({send[o], credit_in[o]})
          2'b10:   credit_q[o] <= credit_q[o] - CRD_W'(1);
          2'b01:   if (credit_q[o] != CRD_MAX) credit_q[o] <= credit_q[o] + CRD_W'(1);
          default: ;
        endcase
      end
      valid_out  <= send;
      credit_out <= pop;
    end
  end

`ifdef NL_ROUTER_PERF_CNT_EN
  logic [31:0] cnt_q [NP];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) cnt_q[o] <= '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (send[o] && (cnt_q[o] != 32'hFFFF_FFFF)) cnt_q[o] <= cnt_q[o] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) flit_cnt[o*32 +: 32] = cnt_q[o];
  end
`else
  assign flit_cnt = '0;
`endif

endmodule
